// File: rtl/chain1_tdo_tx_if.sv
// chain1_tdo_tx_if: response-word handshake from the JTCK-domain producer into the chain-1 TDO transmitter.
interface chain1_tdo_tx_if;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_tag;
  logic        resp_ready;
  modport master (output resp_valid, resp_data, resp_tag, input resp_ready);
  modport slave  (input resp_valid, resp_data, resp_tag, output resp_ready);
endinterface

// File: rtl/chain1_tdo_tx.sv
// chain1_tdo_tx: buffers response words and shifts one frame per DR scan onto JTD1, retiring a word only on a complete scan + JUPDATE.
// Optional CHAIN1_TX_PARITY_EN appends an even-parity bit 36 (FRAME_LEN 37).
module chain1_tdo_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          JTCK,
  input  logic                          JRSTN,
  input  logic                          JCE1,
  input  logic                          JSHIFT,
  input  logic                          JUPDATE,
  input  logic                          JRTI1,
  chain1_tdo_tx_if.slave                rsp,
  output logic                          JTD1,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef CHAIN1_TX_PARITY_EN
  localparam int FRAME_LEN = 37;
`else
  localparam int FRAME_LEN = 36;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [35:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [FRAME_LEN-1:0] sr, ld;
  logic [35:0] frame;
  logic [5:0] cnt;
  logic head_valid, empty, full, push, pop, capture, shift, load_en, shift_en, busy;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rsp.resp_ready = !full;
  assign push = rsp.resp_valid && !full;
  assign fifo_level = wptr - rptr;
  assign frame = empty ? 36'h0 : mem[rptr[AW-1:0]];
`ifdef CHAIN1_TX_PARITY_EN
  assign ld = {^frame, frame};
`else
  assign ld = frame;
`endif
  assign capture = JCE1 && !JSHIFT;
  assign shift = JCE1 && JSHIFT;
  always_ff @(posedge JTCK or negedge JRSTN)
    if (!JRSTN) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = capture ? SHIFT : IDLE;
    else if (state == SHIFT) nxt = (JUPDATE || JRTI1) ? IDLE : SHIFT;
  end
  // busy: still mid-scan this cycle, i.e. neither update nor run-test-idle ends it
  always_comb begin
    busy = state == SHIFT && !JUPDATE && !JRTI1;
    load_en = capture && (state == IDLE || busy);
    shift_en = shift && busy;
    pop = state == SHIFT && JUPDATE && cnt == 6'(FRAME_LEN) && head_valid;
    JTD1 = state == SHIFT ? sr[0] : 1'b0;
  end
  always_ff @(posedge JTCK)
    if (push) mem[wptr[AW-1:0]] <= {rsp.resp_data, 1'b1, rsp.resp_tag};
  always_ff @(posedge JTCK or negedge JRSTN)
    if (!JRSTN) begin
      wptr <= '0;
      rptr <= '0;
      sr <= '0;
      cnt <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (load_en) begin
        sr <= ld;
        cnt <= '0;
        head_valid <= !empty;
      end else if (shift_en) begin
        sr <= sr >> 1;
        cnt <= (cnt == 6'(FRAME_LEN)) ? cnt : cnt + 1'b1;
      end
    end
endmodule

// File: doc/chain1_tdo_tx.md
# chain1_tdo_tx

Response transmitter for JTAG user chain 1: the TDO-side counterpart of the chain-1 instruction receiver. It buffers 32-bit response words (bus read data, register readbacks) produced in the JTCK domain and serialises one 36-bit frame per DR scan onto JTD1, LSB first. A word is retired only after a complete scan followed by JUPDATE, so an aborted scan repeats the same word on the next scan.

## Interface
- FIFO_DEPTH, 4: response FIFO entries; power of two, ≥2.
- JTCK  in  1  chain clock; all state on rising edge.
- JRSTN  in  1  asynchronous active-low reset.
- JCE1  in  1  chain-1 enable (capture/shift qualifier).
- JSHIFT  in  1  shift-DR phase.
- JUPDATE  in  1  update-DR pulse.
- JRTI1  in  1  run-test-idle with chain 1 selected; unused for data, clears abort state (see Operation).
- resp_valid  in  1  producer has a word.
- resp_data  in  32  response payload.
- resp_tag  in  3  response type code from producer.
- resp_ready  out  1  FIFO not full; push when resp_valid & resp_ready.
- JTD1  out  1  serial response bit to TAP.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Frame (36 bits, bit 0 first): [3] valid, [2:0] tag, [35:4] data. Empty FIFO → frame 36'h0 (valid=0).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: JCE1 & !JSHIFT (capture cycle) → load shift register from FIFO head (or empty frame), record head_valid, clear bit count, → SHIFT.
  - SHIFT: each cycle with JCE1 & JSHIFT: shift register right by one, zero fill; count++ (saturates at FRAME_LEN). JUPDATE → DONE-handling (below) → IDLE. JRTI1 with JUPDATE not seen → IDLE, no pop.
  - DONE handling (same cycle as JUPDATE): pop head iff count == FRAME_LEN and head_valid; otherwise no pop.
- JTD1 = shift_reg[0] combinationally; 0 in IDLE.
- FIFO: circular, read/write pointers one bit wider than index; full when MSBs differ and indices equal. Push ignored when full (resp_ready=0). Simultaneous push and pop: both occur, level unchanged; push into empty FIFO during SHIFT does not alter the captured frame.
- Shifts beyond FRAME_LEN output 0; frame still counts as complete.
- JSHIFT without JCE1 ignored. Capture while in SHIFT (new capture without update) reloads from head.

## Timing
- Reset: JTD1=0, resp_ready=1, fifo_level=0, FSM IDLE, pointers 0, shift register 0.
- Push visible in fifo_level one cycle after accepting edge; eligible for the next capture cycle after that.
- Frame bit 0 on JTD1 the cycle after the capture edge; bit k after k shift edges.
- Pop on the JUPDATE edge; fifo_level and resp_ready update the following cycle.
- Reset mid-scan: FIFO contents discarded, frame abandoned, JTD1 to 0 immediately (asynchronous).

## Configuration
- CHAIN1_TX_PARITY_EN defined: FRAME_LEN=37; bit 36 = even parity (XOR) of frame bits [35:0], computed at capture; pop requires 37 shifts.
- Not defined: FRAME_LEN=36; no parity bit; bit 36 onward reads 0.

## Test plan
- Reset, no pushes, one 36-shift scan + JUPDATE → JTD1 stream all 0, fifo_level stays 0.
- Push {tag=3'h1, data=32'hFFFFFFFF}; scan 36 + JUPDATE → bits[3:0]=4'b1001 (LSB first 1,0,0,1), bits 4–35 all 1; fifo_level 1→0.
- Push 32'hABCDEF80 tag 2; scan only 20 bits, JUPDATE → no pop (level 1); full rescan → same frame 36'hABCDEF80A, then level 0.
- Push 5 words with FIFO_DEPTH=4 → resp_ready low after 4th, 5th dropped; four scans return words 1–4 in order; fifth scan returns valid=0.
- Push on same edge as JUPDATE-pop with level 2 → level stays 2; next scan returns the second-pushed word.
- Assert JRSTN low mid-scan (bit 10) with 3 entries → JTD1=0, level 0, resp_ready 1; with CHAIN1_TX_PARITY_EN, data 32'h00000001 tag 0 → bit 36 = 0 (valid+data bit → two ones).
